// File: rtl/fpu_denorm_sched_if.sv
// Requester-side and result-side handshake bundle for fpu_denorm_sched.
// float_t: [65:64] type (0 HALF, 1 SINGLE, 2 DOUBLE), [63:0] raw IEEE bits right-aligned.
interface fpu_denorm_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int FLT_W = 66;
    // denormalized_t: {mantissa[63:0], original float_t}
    localparam int DN_W  = 64 + FLT_W;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0][FLT_W-1:0]   req_flt;
    logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag;
    logic                            out_valid;
    logic                            out_ready;
    logic [DN_W-1:0]                 out_flt;
    logic [ID_W-1:0]                 out_src;
    logic [TAG_W-1:0]                out_tag;
    logic                            out_err;

    modport master (
        output req_valid, req_flt, req_tag, out_ready,
        input  req_ready, out_valid, out_flt, out_src, out_tag, out_err
    );

    modport slave (
        input  req_valid, req_flt, req_tag, out_ready,
        output req_ready, out_valid, out_flt, out_src, out_tag, out_err
    );
endinterface

// File: rtl/fpu_denorm_sched.sv
// Round-robin shared denormalizer: arbiter into S1 input register, then
// denormalize into the S2 output register. One result per cycle sustained.
module fpu_denorm_sched #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fpu_denorm_sched_if.slave    bus,
    output logic                 busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int FLT_W = 66;
    localparam int DN_W  = 64 + FLT_W;

    typedef enum logic [1:0] {
        FMT_HALF   = 2'd0,
        FMT_SINGLE = 2'd1,
        FMT_DOUBLE = 2'd2
    } fmt_e;

    logic              s1_valid;
    logic [FLT_W-1:0]  s1_flt;
    logic [TAG_W-1:0]  s1_tag;
    logic [ID_W-1:0]   s1_src;

    logic              s2_valid;
    logic [DN_W-1:0]   s2_flt;
    logic [TAG_W-1:0]  s2_tag;
    logic [ID_W-1:0]   s2_src;
    logic              s2_err;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win;
    logic              found;
    int unsigned       idx;
    logic              s2_adv;
    logic              s1_take;
    logic              accept;
    logic [64:0]       dn;

    // {err, mantissa}: implicit leading one, fraction MSB-aligned in 64 bits
    function automatic logic [64:0] denorm(input logic [FLT_W-1:0] f);
        logic [64:0] r;
        r = '0;
        case (f[65:64])
            FMT_HALF:   r = {1'b0, 1'b1, f[9:0],  53'd0};
            FMT_SINGLE: r = {1'b0, 1'b1, f[22:0], 40'd0};
            FMT_DOUBLE: r = {1'b0, 1'b1, f[51:0], 11'd0};
            default:    r = {1'b1, 64'd0};
        endcase
        return r;
    endfunction

    assign s2_adv  = s1_valid & (~s2_valid | bus.out_ready);
    assign s1_take = ~s1_valid | s2_adv;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign accept        = found & s1_take & ~flush;
    assign bus.req_ready = (accept && !rst) ? (NUM_REQ'(1) << win) : '0;
    assign dn            = denorm(s1_flt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_flt   <= '0;
            s1_tag   <= '0;
            s1_src   <= '0;
            s2_valid <= 1'b0;
            s2_flt   <= '0;
            s2_tag   <= '0;
            s2_src   <= '0;
            s2_err   <= 1'b0;
            rr_ptr   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= 1'b1;
                s2_flt   <= {dn[63:0], s1_flt};
                s2_err   <= dn[64];
                s2_tag   <= s1_tag;
                s2_src   <= s1_src;
            end else if (s2_valid && bus.out_ready) begin
                s2_valid <= 1'b0;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_flt   <= bus.req_flt[win];
                s1_tag   <= bus.req_tag[win];
                s1_src   <= win;
                rr_ptr   <= (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end else if (s1_take) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_flt   = s2_flt;
    assign bus.out_src   = s2_src;
    assign bus.out_tag   = s2_tag;
    assign bus.out_err   = s2_err;
    assign busy          = s1_valid | s2_valid;
endmodule

// File: tb/tb_fpu_denorm_sched.sv
// Bench for fpu_denorm_sched: queue-based occupancy model checked every cycle,
// plus directed scenarios with their own targeted checks.
module tb_fpu_denorm_sched;
    localparam int N  = 4;
    localparam int TW = 6;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;

    always #5 clk = ~clk;

    fpu_denorm_sched_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

    fpu_denorm_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus.slave),
        .busy (busy)
    );

    typedef struct {
        logic [65:0]   flt;
        logic [TW-1:0] tag;
        int            src;
        bit            vis;
    } op_t;

    int  total = 0;
    int  bad   = 0;
    op_t pipe[$];
    int  rr = 0;
    int  dut_grants[$];
    int  dut_outs[$];

    function automatic logic [63:0] ref_mant(input logic [65:0] f, output bit err);
        int fw;
        logic [63:0] frac;
        err = 0;
        case (f[65:64])
            2'd0: fw = 10;
            2'd1: fw = 23;
            2'd2: fw = 52;
            default: begin err = 1; return 64'd0; end
        endcase
        frac = f[63:0] & ((64'd1 << fw) - 64'd1);
        return ((64'd1 << fw) | frac) << (63 - fw);
    endfunction

    // One clock: check DUT against model at negedge, advance model at posedge.
    task automatic tick();
        int w;
        bit nv, s2free, take, ev, e;
        logic [N-1:0] exp_ready;
        logic [63:0] m;
        op_t o;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i = (rr + k) % N;
            if (w < 0 && bus.req_valid[i]) w = i;
        end
        nv     = (pipe.size() == 2) || (pipe.size() == 1 && !pipe[0].vis);
        s2free = !(pipe.size() > 0 && pipe[0].vis) || bus.out_ready;
        take   = !nv || s2free;
        exp_ready = (w >= 0 && take && !flush && !rst) ? (N'(1) << w) : '0;
        total++;
        if (bus.req_ready !== exp_ready) begin
            bad++;
            $display("FAIL req_ready got=%b want=%b t=%0t", bus.req_ready, exp_ready, $time);
        end
        ev = pipe.size() > 0 && pipe[0].vis;
        total++;
        if (bus.out_valid !== ev) begin
            bad++;
            $display("FAIL out_valid got=%b want=%b t=%0t", bus.out_valid, ev, $time);
        end
        if (ev) begin
            m = ref_mant(pipe[0].flt, e);
            total++;
            if ({bus.out_flt, bus.out_src, bus.out_tag, bus.out_err} !==
                {m, pipe[0].flt, IW'(pipe[0].src), pipe[0].tag, e}) begin
                bad++;
                $display("FAIL out_data got=%h/%0d/%h/%b want=%h/%0d/%h/%b t=%0t",
                         bus.out_flt, bus.out_src, bus.out_tag, bus.out_err,
                         {m, pipe[0].flt}, pipe[0].src, pipe[0].tag, e, $time);
            end
        end
        total++;
        if (busy !== (pipe.size() > 0)) begin
            bad++;
            $display("FAIL busy got=%b want=%b t=%0t", busy, pipe.size() > 0, $time);
        end
        for (int k = 0; k < N; k++) if (bus.req_ready[k]) dut_grants.push_back(k);
        if (bus.out_valid && bus.out_ready && !flush && !rst) dut_outs.push_back(int'(bus.out_src));
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            rr = 0;
        end else if (flush) begin
            pipe.delete();
        end else begin
            if (pipe.size() > 0 && pipe[0].vis && bus.out_ready) void'(pipe.pop_front());
            if (pipe.size() > 0 && !pipe[0].vis) begin
                o = pipe[0];
                o.vis = 1;
                pipe[0] = o;
            end
            if (exp_ready != 0) begin
                o.flt = bus.req_flt[w];
                o.tag = bus.req_tag[w];
                o.src = w;
                o.vis = 0;
                pipe.push_back(o);
                rr = (w + 1) % N;
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] fmt, input logic [63:0] bits,
                           input logic [TW-1:0] tag);
        bus.req_flt[i] = {fmt, bits};
        bus.req_tag[i] = tag;
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++)
            set_req(i, 2'($urandom_range(0, 3)), {$urandom, $urandom}, TW'($urandom));
    endtask

    task automatic idle_ticks(input int n);
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        flush = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        rand_reqs();
        repeat (2) tick();
        total++;
        if ({bus.out_flt, bus.out_src, bus.out_tag, bus.out_err} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", bus.out_flt);
        end
        rst = 1'b0;
        idle_ticks(1);
    endtask

    task automatic test_round_robin();
        dut_grants.delete();
        dut_outs.delete();
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_reqs();
            tick();
        end
        idle_ticks(3);
        total++;
        if (dut_grants != '{0, 1, 2, 3, 0, 1}) begin
            bad++;
            $display("FAIL rr_grants got=%p want=0,1,2,3,0,1", dut_grants);
        end
        total++;
        if (dut_outs != '{0, 1, 2, 3, 0, 1}) begin
            bad++;
            $display("FAIL rr_outs got=%p want=0,1,2,3,0,1", dut_outs);
        end
    endtask

    task automatic test_rr_ptr();
        dut_grants.delete();
        rand_reqs();
        bus.req_valid = 4'b1010;
        repeat (2) tick();
        idle_ticks(3);
        total++;
        if (dut_grants != '{3, 1}) begin
            bad++;
            $display("FAIL rr_ptr2 got=%p want=3,1", dut_grants);
        end
    endtask

    task automatic test_half();
        set_req(0, 2'd0, 64'h155, 6'd5);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_flt[129:66] !== 64'hAAA0_0000_0000_0000 ||
            bus.out_src !== 2'd0 || bus.out_tag !== 6'd5 || bus.out_err !== 1'b0) begin
            bad++;
            $display("FAIL half got=%b/%h/%0d/%0d/%b want=1/aaa0000000000000/0/5/0",
                     bus.out_valid, bus.out_flt[129:66], bus.out_src, bus.out_tag, bus.out_err);
        end
        idle_ticks(2);
    endtask

    task automatic test_stall();
        int s;
        logic [129+IW+TW+1:0] held;
        s = rr;
        dut_grants.delete();
        dut_outs.delete();
        bus.req_valid = '1;
        bus.out_ready = 1'b0;
        rand_reqs();
        repeat (2) tick();
        held = {bus.out_flt, bus.out_src, bus.out_tag, bus.out_err, bus.out_valid};
        for (int c = 0; c < 3; c++) begin
            rand_reqs();
            tick();
            total++;
            if ({bus.out_flt, bus.out_src, bus.out_tag, bus.out_err, bus.out_valid} !== held) begin
                bad++;
                $display("FAIL stall_hold got=%h want=%h", bus.out_flt, held[129+IW+TW+1:IW+TW+2]);
            end
        end
        total++;
        if (dut_grants.size() != 2) begin
            bad++;
            $display("FAIL stall_accepts got=%0d want=2", dut_grants.size());
        end
        bus.out_ready = 1'b1;
        repeat (4) tick();
        total++;
        if (dut_outs != '{s % N, (s + 1) % N, (s + 2) % N, (s + 3) % N}) begin
            bad++;
            $display("FAIL stall_release got=%p want=%0d,%0d,%0d,%0d", dut_outs,
                     s % N, (s + 1) % N, (s + 2) % N, (s + 3) % N);
        end
        idle_ticks(3);
    endtask

    task automatic test_flush();
        int rr_before;
        dut_grants.delete();
        bus.req_valid = '1;
        bus.out_ready = 1'b0;
        rand_reqs();
        repeat (2) tick();
        rr_before = rr;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear got=%b/%b want=0/0", bus.out_valid, busy);
        end
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (dut_grants.size() != 3 || dut_grants[2] != rr_before) begin
            bad++;
            $display("FAIL flush_rr got=%p want_last=%0d", dut_grants, rr_before);
        end
        idle_ticks(3);
    endtask

    task automatic test_reset_mid();
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            rand_reqs();
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== '0 ||
            bus.out_tag !== '0 || bus.out_flt !== '0) begin
            bad++;
            $display("FAIL rst_mid got=%b/%b/%b/%h want=0/0/0/0",
                     bus.out_valid, busy, bus.req_ready, bus.out_tag);
        end
        pipe.delete();
        rr = 0;
        tick();
        rst = 1'b0;
        dut_outs.delete();
        idle_ticks(3);
        total++;
        if (dut_outs.size() != 0) begin
            bad++;
            $display("FAIL rst_stale got=%0d want=0", dut_outs.size());
        end
    endtask

    task automatic test_invalid();
        set_req(2, 2'd3, 64'h0123_4567_89AB_CDEF, 6'h2A);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_flt[129:66] !== 64'd0 ||
            bus.out_src !== 2'd2 || bus.out_tag !== 6'h2A) begin
            bad++;
            $display("FAIL invalid got=%b/%b/%h/%0d/%h want=1/1/0/2/2a", bus.out_valid,
                     bus.out_err, bus.out_flt[129:66], bus.out_src, bus.out_tag);
        end
        idle_ticks(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = N'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 99) < 3);
            rand_reqs();
            tick();
        end
        idle_ticks(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'd0, 64'd0, '0);
        #1;
        test_reset();
        test_round_robin();
        test_rr_ptr();
        test_half();
        test_stall();
        test_flush();
        test_reset_mid();
        test_invalid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
